// File: rtl/digit_stream_tx.sv
// Captures num on start, double-dabbles it to BCD and sends digits MSD-first on data under a timed strobe; start/busy/done handshake, no backpressure.
// Latency NUM_W+2+2*n*HOLD_CYCLES from accept to done; define DIGIT_LZ_SUPPRESS_EN to skip leading zero digits.
module digit_stream_tx #(
   parameter int DIGITS      = 6,
   parameter int NUM_W       = 32,
   parameter int HOLD_CYCLES = 1200000
) (
   input  logic             hwclk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [NUM_W-1:0] num,
   output logic [3:0]       data,
   output logic             strobe,
   output logic             busy,
   output logic             done,
   output logic             ovf
);

   localparam int BCD_W  = 4 * DIGITS;
   localparam int CNT_W  = $clog2(NUM_W + 1);
   localparam int HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CNT_W-1:0]  CONV_LAST = CNT_W'(NUM_W);
   localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES - 1);
   localparam logic [IDX_W-1:0]  IDX_TOP   = IDX_W'(DIGITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONV,
      S_LOAD,
      S_HOLD,
      S_GAP,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [NUM_W-1:0]    r_shift;
   logic [BCD_W-1:0]    r_bcd;
   logic                r_ovf;
   logic [CNT_W-1:0]    r_bit_cnt;
   logic [HCNT_W-1:0]   r_hold_cnt;
   logic [IDX_W-1:0]    r_idx;
   logic [3:0]          r_data;

   logic [BCD_W-1:0]    w_adj;
   logic [BCD_W-1:0]    w_bcd_nxt;
   logic [NUM_W-1:0]    w_shift_nxt;
   logic                w_carry;
   logic [IDX_W-1:0]    w_first_idx;
   logic [IDX_W-1:0]    w_idx_dec;

   // One double-dabble step; a bit leaving the top nibble means num >= 10^DIGITS.
   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_bcd[4*i +: 4] > 4'd4) begin
            w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
         end
      end
      {w_carry, w_bcd_nxt, w_shift_nxt} = {w_adj, r_shift, 1'b0};
   end

   always_comb begin
`ifdef DIGIT_LZ_SUPPRESS_EN
      w_first_idx = '0;
      for (int i = 1; i < DIGITS; i++) begin
         if (r_bcd[4*i +: 4] != 4'd0) begin
            w_first_idx = IDX_W'(i);
         end
      end
`else
      w_first_idx = IDX_TOP;
`endif
   end

   assign w_idx_dec = r_idx - 1'b1;

   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      strobe      = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) w_state_nxt = S_CONV;
         end
         // The final CONV cycle (counter at terminal) lets ovf and BCD settle before LOAD.
         S_CONV: if (r_bit_cnt == CONV_LAST) w_state_nxt = S_LOAD;
         S_LOAD: w_state_nxt = S_HOLD;
         S_HOLD: begin
            strobe = 1'b1;
            if (r_hold_cnt == HOLD_LAST) w_state_nxt = S_GAP;
         end
         S_GAP: begin
            if (r_hold_cnt == HOLD_LAST) begin
               w_state_nxt = (r_idx == '0) ? S_DONE : S_HOLD;
            end
         end
         S_DONE: begin
            busy        = 1'b0;
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift    <= '0;
         r_bcd      <= '0;
         r_ovf      <= 1'b0;
         r_bit_cnt  <= '0;
         r_hold_cnt <= '0;
         r_idx      <= '0;
         r_data     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_shift   <= num;
                  r_bcd     <= '0;
                  r_ovf     <= 1'b0;
                  r_bit_cnt <= '0;
               end
            end
            S_CONV: begin
               if (r_bit_cnt != CONV_LAST) begin
                  r_bcd     <= w_bcd_nxt;
                  r_shift   <= w_shift_nxt;
                  r_ovf     <= r_ovf | w_carry;
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end
            S_LOAD: begin
               r_idx      <= w_first_idx;
               r_hold_cnt <= '0;
               r_data     <= r_bcd[4*w_first_idx +: 4];
            end
            S_HOLD: begin
               r_hold_cnt <= (r_hold_cnt == HOLD_LAST) ? '0 : r_hold_cnt + 1'b1;
            end
            S_GAP: begin
               if (r_hold_cnt == HOLD_LAST) begin
                  r_hold_cnt <= '0;
                  if (r_idx != '0) begin
                     r_idx  <= w_idx_dec;
                     r_data <= r_bcd[4*w_idx_dec +: 4];
                  end
               end else begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign data = r_data;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_digit_stream_tx.sv
// Bench for digit_stream_tx: stimulus pushes expected transfers into queues, a negedge monitor pops and checks them.
module tb_digit_stream_tx;

   localparam int DIGITS = 6;
   localparam int NUM_W  = 32;
   localparam int HOLD   = 4;

   logic             hwclk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [NUM_W-1:0] num;
   logic [3:0]       data;
   logic             strobe;
   logic             busy;
   logic             done;
   logic             ovf;

   digit_stream_tx #(.DIGITS(DIGITS), .NUM_W(NUM_W), .HOLD_CYCLES(HOLD)) dut (
      .hwclk (hwclk),
      .rst_n (rst_n),
      .start (start),
      .num   (num),
      .data  (data),
      .strobe(strobe),
      .busy  (busy),
      .done  (done),
      .ovf   (ovf)
   );

   always #5 hwclk = ~hwclk;

   typedef struct {
      int   e0;
      int   lat;
      logic eovf;
      int   ndig;
   } txn_t;

   txn_t exp_q[$];
   int   dig_q[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   always @(posedge hwclk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic bad(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: event not expected / not seen (cycle %0d)", name, cyc);
   endtask

   // Call at a negedge; the following posedge is the accept edge E0.
   task automatic send(input logic [31:0] v, input logic [23:0] bcd, input int ndig,
                       input int lat, input logic eovf);
      txn_t tx;
      tx.e0   = cyc + 1;
      tx.lat  = lat;
      tx.eovf = eovf;
      tx.ndig = ndig;
      exp_q.push_back(tx);
      for (int i = ndig - 1; i >= 0; i--) dig_q.push_back(int'(bcd[4*i +: 4]));
      start = 1'b1;
      num   = v;
      @(negedge hwclk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int max);
      int k = 0;
      do begin
         @(negedge hwclk);
         k++;
      end while (!done && k < max);
      if (!done) bad("wait_done_timeout");
   endtask

   task automatic wait_rises(input int n, input int max);
      int   seen = 0;
      int   k = 0;
      logic p = strobe;
      while (seen < n && k < max) begin
         @(negedge hwclk);
         k++;
         if (strobe && !p) seen++;
         p = strobe;
      end
      if (seen < n) bad("strobe_rise_timeout");
   endtask

   // Monitor
   logic prev_strobe = 1'b0;
   logic prev_done = 1'b0;
   int   hi_len = 0;
   int   lo_len = 0;
   int   sent = 0;

   always @(negedge hwclk) begin
      txn_t t;
      int   d;
      if (!rst_n) begin
         chk("done_in_reset", done, 0);
         prev_strobe = 1'b0;
         prev_done   = 1'b0;
         hi_len      = 0;
         lo_len      = 0;
         sent        = 0;
      end else begin
         if (prev_done) chk("done_width", done, 0);
         if (done) begin
            if (exp_q.size() == 0) begin
               bad("unexpected_done");
            end else begin
               t = exp_q.pop_front();
               chk("done_latency", cyc - t.e0, t.lat);
               chk("ovf_at_done", ovf, t.eovf);
               chk("busy_at_done", busy, 0);
               chk("digits_sent", sent, t.ndig);
               chk("last_gap_len", lo_len, HOLD);
            end
            sent   = 0;
            lo_len = 0;
         end else if (strobe && !prev_strobe) begin
            if (dig_q.size() == 0) begin
               bad("unexpected_strobe");
            end else begin
               d = dig_q.pop_front();
               chk("digit", data, d);
            end
            if (sent == 0 && exp_q.size() > 0) chk("first_rise_latency", cyc - exp_q[0].e0, NUM_W + 2);
            if (sent > 0) chk("gap_len", lo_len, HOLD);
            chk("busy_in_xfer", busy, 1);
            sent++;
            hi_len = 1;
            lo_len = 0;
         end else if (strobe) begin
            hi_len++;
         end else if (prev_strobe) begin
            chk("high_len", hi_len, HOLD);
            lo_len = 1;
         end else if (lo_len > 0) begin
            lo_len++;
         end
         prev_strobe = strobe;
         prev_done   = done;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      num   = '0;
      repeat (3) @(negedge hwclk);
      chk("rst_data", data, 0);
      chk("rst_strobe", strobe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", ovf, 0);
      rst_n = 1'b1;
      @(negedge hwclk);

      send(123456, 24'h123456, 6, 82, 1'b0);
      wait_done(200);
      @(negedge hwclk);

      send(1234567, 24'h234567, 6, 82, 1'b1);
      repeat (NUM_W + 1) @(negedge hwclk);
      chk("ovf_at_load", ovf, 1);
      wait_done(200);
      @(negedge hwclk);

`ifdef DIGIT_LZ_SUPPRESS_EN
      send(42, 24'h000042, 2, 50, 1'b0);
`else
      send(42, 24'h000042, 6, 82, 1'b0);
`endif
      chk("ovf_cleared_on_accept", ovf, 0);
      chk("busy_after_accept", busy, 1);
      wait_done(200);
      @(negedge hwclk);

`ifdef DIGIT_LZ_SUPPRESS_EN
      send(0, 24'h000000, 1, 42, 1'b0);
`else
      send(0, 24'h000000, 6, 82, 1'b0);
`endif
      wait_done(200);
      @(negedge hwclk);

      // start during HOLD and during DONE is ignored; start in the next IDLE cycle is taken.
      send(123456, 24'h123456, 6, 82, 1'b0);
      wait_rises(1, 100);
      start = 1'b1;
      num   = 999;
      @(negedge hwclk);
      start = 1'b0;
      wait_done(200);
      start = 1'b1;
      num   = 5;
      @(negedge hwclk);
`ifdef DIGIT_LZ_SUPPRESS_EN
      send(5, 24'h000005, 1, 42, 1'b0);
`else
      send(5, 24'h000005, 6, 82, 1'b0);
`endif
      wait_done(200);
      @(negedge hwclk);

      // Abort mid-HOLD of the third digit.
      send(1234567, 24'h234567, 6, 82, 1'b1);
      wait_rises(3, 200);
      @(negedge hwclk);
      rst_n = 1'b0;
      #1;
      chk("abort_strobe", strobe, 0);
      chk("abort_busy", busy, 0);
      chk("abort_data", data, 0);
      chk("abort_ovf", ovf, 0);
      chk("abort_done", done, 0);
      exp_q.delete();
      dig_q.delete();
      repeat (3) @(negedge hwclk);
      rst_n = 1'b1;
      @(negedge hwclk);

`ifdef DIGIT_LZ_SUPPRESS_EN
      send(7, 24'h000007, 1, 42, 1'b0);
`else
      send(7, 24'h000007, 6, 82, 1'b0);
`endif
      wait_done(200);
      repeat (4) @(negedge hwclk);
      chk("txn_queue_drained", exp_q.size(), 0);
      chk("digit_queue_drained", dig_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
